// File: rtl/pc_pkg.sv
// pc_pkg: shared select encodings for the program counter
package pc_pkg;
  localparam int PC_SEL_W = 2;
  typedef enum logic [PC_SEL_W-1:0] {
    PC_NEXT = 2'd0,
    PC_KEEP = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_t;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational next-PC select (increment, hold, load)
// PC_ADDR_MASK_EN clears bits [WORD_SIZE-1:ADDR_SIZE] of the result
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 14
) (
  input  logic [WORD_SIZE-1:0] cur_pc,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic [PC_SEL_W-1:0]  sel,
  output logic [WORD_SIZE-1:0] next_pc
);
  logic [WORD_SIZE-1:0] raw;
  if (ADDR_SIZE < 1 || ADDR_SIZE > WORD_SIZE) begin : g_bad_addr_size
    $error("pc_next_sel: ADDR_SIZE must be in 1..WORD_SIZE");
  end
  // reserved and unknown selects fall into default and hold
  always_comb begin
    raw = cur_pc;
    case (sel)
      PC_NEXT: raw = cur_pc + WORD_SIZE'(1);
      PC_LOAD: raw = instr;
      default: raw = cur_pc;
    endcase
  end
`ifdef PC_ADDR_MASK_EN
  assign next_pc = raw & ~({WORD_SIZE{1'b1}} << ADDR_SIZE);
`else
  assign next_pc = raw;
`endif
endmodule

// File: rtl/pc.sv
// pc: program counter register with asynchronous active-low reset
// PC_ADDR_MASK_EN restricts the PC (and its reset value) to ADDR_SIZE bits
module pc
  import pc_pkg::*;
#(
  parameter int                   WORD_SIZE   = 32,
  parameter int                   ADDR_SIZE   = 14,
  parameter logic [WORD_SIZE-1:0] RESET_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] instr,
  input  logic [PC_SEL_W-1:0]  sel,
  output logic [WORD_SIZE-1:0] out
);
`ifdef PC_ADDR_MASK_EN
  localparam logic [WORD_SIZE-1:0] RST_PC = RESET_VALUE & ~({WORD_SIZE{1'b1}} << ADDR_SIZE);
`else
  localparam logic [WORD_SIZE-1:0] RST_PC = RESET_VALUE;
`endif
  logic [WORD_SIZE-1:0] next_pc;
  pc_next_sel #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) u_next (
    .cur_pc (out),
    .instr  (instr),
    .sel    (sel),
    .next_pc(next_pc)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) out <= RST_PC;
    else      out <= next_pc;
  a_sel_known: assert property (@(posedge clk) disable iff (!rst) !$isunknown(sel));
endmodule

// File: tb/tb_pc.sv
// tb_pc: randomized scoreboard bench for pc against an arithmetic reference model
module tb_pc;
  import pc_pkg::*;
  localparam int W = 32;
  localparam int A = 14;
  typedef struct {
    logic [W-1:0] v;
    string        nm;
  } exp_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] instr = '0;
  logic [1:0]   sel = 2'd0;
  logic [W-1:0] out;
  logic [W-1:0] model = '0;
  exp_t         q[$];
  exp_t         e;
  int           checks = 0;
  int           errors = 0;

  pc #(.WORD_SIZE(W), .ADDR_SIZE(A), .RESET_VALUE('0)) dut (
    .clk  (clk),
    .rst  (rst),
    .instr(instr),
    .sel  (sel),
    .out  (out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fit(input logic [W-1:0] v);
`ifdef PC_ADDR_MASK_EN
    return W'(64'(v) % (64'd1 << A));
`else
    return v;
`endif
  endfunction

  function automatic logic [W-1:0] ref_next(input logic [W-1:0] cur, input logic [1:0] s,
                                            input logic [W-1:0] i);
    if (s == 2'd0) return fit(W'((64'(cur) + 64'd1) % (64'd1 << W)));
    if (s == 2'd2) return fit(i);
    return cur;
  endfunction

  // inputs change at negedge; a reset edge gets its own mid-cycle expectation
  task automatic cyc(input logic r, input logic [1:0] s, input logic [W-1:0] i, input string nm);
    @(negedge clk);
    if (r != rst) begin
      if (!r) model = fit('0);
      q.push_back('{model, r ? "rst_release" : "rst_async"});
    end
    rst = r;
    sel = s;
    instr = i;
    model = r ? ref_next(model, s, i) : fit('0);
    q.push_back('{model, nm});
  endtask

  initial forever begin
    @(posedge clk or rst);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (out !== e.v) begin
        errors++;
        $display("FAIL %s: out=%h expected=%h", e.nm, out, e.v);
      end
    end
  end

  initial begin
    repeat (4) cyc(1'b0, 2'($urandom_range(0, 3)), $urandom, "rst_hold");
    repeat (10) cyc(1'b1, 2'd0, $urandom, "next_count");
    repeat (10) cyc(1'b1, 2'd2, $urandom, "load_rand");
    cyc(1'b1, 2'd2, 32'h1215_3524, "load_fixed");
    cyc(1'b1, 2'd2, 32'hFFFF_FFFF, "load_ones");
    cyc(1'b1, 2'd0, $urandom, "next_wrap");
    cyc(1'b1, 2'd2, 32'h0000_0005, "load_5");
    repeat (5) cyc(1'b1, 2'd1, $urandom, "keep");
    repeat (2) cyc(1'b1, 2'd3, $urandom, "reserved_hold");
    repeat (3) cyc(1'b1, 2'd0, $urandom, "next_pre_rst");
    cyc(1'b0, 2'd0, $urandom, "mid_rst");
    repeat (3) cyc(1'b1, 2'd1, $urandom, "keep_after_rst");
    repeat (60) cyc(($urandom_range(0, 15) != 0), 2'($urandom_range(0, 3)), $urandom, "random_mix");
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: pending=%0d expected=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
